// File: rtl/conv_window_buffer_pkg.sv
// Shared constants, FSM state type and window indexing for the 3x3 window buffer.
package conv_pkg;

  localparam int KERNEL             = 3;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Flat position of window tap (i = row from top, j = col from left).
  function automatic int idx(input int i, input int j);
    return KERNEL * i + j;
  endfunction

endpackage

// File: rtl/conv_window_buffer_line_ram.sv
// One line of pixel history: single write port, asynchronous read.
module line_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 66,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the incoming pixel; the old value at addr is read in the same cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// Streams a square plane in raster order and emits 3x3 windows with optional
// zero "same" padding and stride 2.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid keeps its payload stable until the transfer; ready
// may depend combinationally on the consumer's ready, never the reverse.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int MAX_IMAGE_SIZE = 64,
  parameter int SIZE_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [SIZE_WIDTH-1:0]        IMAGE_SIZE,
  input  logic                         Pad_en,
  input  logic                         Stride2,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [9*DATA_WIDTH-1:0]      out_window,
  output logic [SIZE_WIDTH-1:0]        out_row,
  output logic [SIZE_WIDTH-1:0]        out_col,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         Done_1row,
  output logic                         Done_frame,
  output logic                         Busy,
  output logic                         Error_cfg,
  output logic                         Error_tlast,
  output logic [1:0]                   dbg_state
);

  localparam int ADDR_W = $clog2(MAX_IMAGE_SIZE + 2);
  localparam logic [SIZE_WIDTH-1:0] ONE   = SIZE_WIDTH'(1);
  localparam logic [SIZE_WIDTH-1:0] TWO   = SIZE_WIDTH'(2);
  localparam logic [SIZE_WIDTH-1:0] THREE = SIZE_WIDTH'(3);
  localparam logic [SIZE_WIDTH-1:0] MAX_N = SIZE_WIDTH'(MAX_IMAGE_SIZE);

  state_t                state;
  logic [SIZE_WIDTH-1:0] v_r, vr, vc;
  logic                  pad_r, stride_r, sel;
  logic [DATA_WIDTH-1:0] win [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] col [KERNEL];
  logic [DATA_WIDTH-1:0] ram_a_q, ram_b_q, pixel;
  logic [9*DATA_WIDTH-1:0] next_flat;
  logic [SIZE_WIDTH-1:0] last_v, last_real, win_row, win_col;
  logic is_pad, stall, beat, advance, emit, row_end, plane_end, tlast_exp, cfg_ok;

  assign last_v    = v_r - ONE;
  assign last_real = pad_r ? v_r - TWO : v_r - ONE;
  assign is_pad    = pad_r && (vr == '0 || vr == last_v || vc == '0 || vc == last_v);
  assign stall     = m_axis_tvalid && !m_axis_tready;
  assign s_axis_tready = (state == ST_RUN) && !is_pad && !stall;
  assign beat      = s_axis_tvalid && s_axis_tready;
  assign advance   = (state == ST_RUN) && !stall && (is_pad || s_axis_tvalid);
  assign pixel     = is_pad ? '0 : s_axis_tdata;
  assign win_row   = vr - TWO;
  assign win_col   = vc - TWO;
  assign emit      = advance && vr >= TWO && vc >= TWO &&
                     (!stride_r || (!win_row[0] && !win_col[0]));
  assign row_end   = vc == last_v;
  assign plane_end = row_end && vr == last_v;
  assign tlast_exp = vr == last_real && vc == last_real;
  assign cfg_ok    = IMAGE_SIZE <= MAX_N && (Pad_en ? IMAGE_SIZE >= ONE : IMAGE_SIZE >= THREE);
  assign Busy      = state != ST_IDLE;
  assign dbg_state = state;

  // sel=0: ram_a holds row vr-2 (top), ram_b holds row vr-1; roles swap per row.
  line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_IMAGE_SIZE + 2), .ADDR_W(ADDR_W)) u_ram_a (
    .clk(clk), .we(advance && !sel), .addr(vc[ADDR_W-1:0]), .wdata(pixel), .rdata(ram_a_q)
  );
  line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_IMAGE_SIZE + 2), .ADDR_W(ADDR_W)) u_ram_b (
    .clk(clk), .we(advance && sel), .addr(vc[ADDR_W-1:0]), .wdata(pixel), .rdata(ram_b_q)
  );

  // New window column and the window as it will look after this shift.
  always_comb begin
    col[0]    = sel ? ram_b_q : ram_a_q;
    col[1]    = sel ? ram_a_q : ram_b_q;
    col[2]    = pixel;
    next_flat = '0;
    for (int i = 0; i < KERNEL; i++) begin
      next_flat[idx(i, 0)*DATA_WIDTH +: DATA_WIDTH] = win[i][1];
      next_flat[idx(i, 1)*DATA_WIDTH +: DATA_WIDTH] = win[i][2];
      next_flat[idx(i, 2)*DATA_WIDTH +: DATA_WIDTH] = col[i];
    end
  end

  // Shift the 3x3 window left by one column on every advanced pixel.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < KERNEL; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
        win[i][2] <= col[i];
      end
    end
  end

  // FSM, virtual-pixel counters, status pulses and sticky errors.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      v_r         <= '0;
      vr          <= '0;
      vc          <= '0;
      pad_r       <= 1'b0;
      stride_r    <= 1'b0;
      sel         <= 1'b0;
      Done_1row   <= 1'b0;
      Done_frame  <= 1'b0;
      Error_cfg   <= 1'b0;
      Error_tlast <= 1'b0;
    end else begin
      Done_1row  <= 1'b0;
      Done_frame <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (cfg_ok) begin
              v_r         <= Pad_en ? IMAGE_SIZE + TWO : IMAGE_SIZE;
              pad_r       <= Pad_en;
              stride_r    <= Stride2;
              vr          <= '0;
              vc          <= '0;
              sel         <= 1'b0;
              Error_cfg   <= 1'b0;
              Error_tlast <= 1'b0;
              state       <= ST_RUN;
            end else begin
              Error_cfg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (beat && (s_axis_tlast != tlast_exp)) Error_tlast <= 1'b1;
          if (advance) begin
            Done_1row <= !is_pad && vc == last_real;
            if (row_end) begin
              vc  <= '0;
              vr  <= vr + ONE;
              sel <= ~sel;
            end else begin
              vc <= vc + ONE;
            end
            if (plane_end) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!m_axis_tvalid || m_axis_tready) begin
            state      <= ST_IDLE;
            Done_frame <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-stage output register; reloads in the same cycle it handshakes.
  always_ff @(posedge clk) begin
    if (Reset) begin
      m_axis_tvalid <= 1'b0;
      out_window    <= '0;
      out_row       <= '0;
      out_col       <= '0;
    end else if (emit) begin
      m_axis_tvalid <= 1'b1;
      out_window    <= next_flat;
      out_row       <= win_row;
      out_col       <= win_col;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised successor of the 3x3 conv input line buffer.
- Sequences rows on its own: one Start pulse per channel-plane replaces the per-row stream pulses.
- Runtime image size up to MAX_IMAGE_SIZE, optional zero "same" padding, stride 1 or 2.
- Emits raster-ordered 3x3 windows through a valid/ready output with full backpressure. Sits between the AXI-Stream DDR reader and the conv MAC array.

Parameters:
- DATA_WIDTH, 16, pixel width (signed fixed point, passed through untouched).
- MAX_IMAGE_SIZE, 64, largest supported square image side N.
- SIZE_WIDTH, 8, width of the IMAGE_SIZE and coordinate ports.

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; samples IMAGE_SIZE/Pad_en/Stride2 and begins a plane; ignored unless IDLE
- IMAGE_SIZE  in  SIZE_WIDTH  N, side length of the square plane
- Pad_en  in  1  1 = zero-pad one pixel on every border (output NxN)
- Stride2  in  1  1 = emit only windows whose output row and col are both even
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  marks last pixel of plane (checked only)
- s_axis_tready  out  1  input ready
- out_window  out  9*DATA_WIDTH  w_ij at bits [(3i+j)*DATA_WIDTH +: DATA_WIDTH], i = row (0 top), j = col (0 left)
- out_row, out_col  out  SIZE_WIDTH each  output coordinate of the window
- m_axis_tvalid  out  1  window valid
- m_axis_tready  in  1  consumer ready
- Done_1row  out  1  pulse after the last real pixel of each input row is accepted
- Done_frame  out  1  pulse at plane completion
- Busy  out  1  state != IDLE
- Error_cfg  out  1  sticky; illegal IMAGE_SIZE at Start; cleared by next legal Start or Reset
- Error_tlast  out  1  sticky; tlast mismatch; cleared by next legal Start or Reset

Behaviour:
- Reset: every output 0, state IDLE, all counters 0. Line-memory contents are don't-care. Reset mid-plane aborts immediately; no Done pulses.
- Legal N: 3..MAX_IMAGE_SIZE with Pad_en=0, 1..MAX_IMAGE_SIZE with Pad_en=1. An illegal N sets Error_cfg and the block stays IDLE.
- States: IDLE -> RUN on a legal Start. RUN -> FLUSH when the last virtual pixel is consumed. FLUSH -> IDLE once the output register is empty; Done_frame pulses in that cycle.
- Virtual pixel grid: V x V, raster order; V = N+2 when padded, else N. With padding, border positions are zero and consume no AXI beat.
- One virtual pixel advances per cycle when both hold:
  - it is a pad pixel, or s_axis_tvalid && s_axis_tready;
  - no stall: a stall is m_axis_tvalid && !m_axis_tready.
- s_axis_tready = RUN && current position is real && no stall. It is combinational from state and m_axis_tready.
- Storage:
  - two line memories of MAX_IMAGE_SIZE+2 entries, asynchronous read, rotating row roles;
  - a 3x3 shift register fed by {line1[vc], line0[vc], pixel}.
- A window completes when pixel (vr,vc) with vr>=2 and vc>=2 enters. Its coordinate is (vr-2, vc-2).
- Stride2 suppresses emission when either coordinate is odd; suppressed windows never stall the engine.
- Latency: m_axis_tvalid rises the cycle after the completing pixel is consumed.
- Output register: single stage. out_window, out_row and out_col stay stable while m_axis_tvalid && !m_axis_tready. A new window may load in the same cycle the previous one handshakes, giving 1 window/cycle throughput.
- Row wrap: vc returns to 0 and vr increments. Window columns never mix rows.
- tlast is informational. Error_tlast is set if tlast=1 on any accepted beat except real pixel (N-1,N-1), or tlast=0 on that beat. Counting continues regardless.
- Start while Busy is ignored, with no error raised.

Decomposition:
- Package conv_pkg holds: KERNEL=3, state enum {IDLE, RUN, FLUSH}, a window-index function idx(i,j)=3i+j, and the default DATA_WIDTH.
- Sub-module line_ram: single-write, single-async-read register array, depth MAX_IMAGE_SIZE+2, instantiated twice.
- Counters, FSM, shift window and output register stay in the top module.

Test Plan:
- N=4, Pad_en=0, Stride2=0, pixels 0x0000..0x000F, m_axis_tready=1 -> exactly 4 windows at (0,0),(0,1),(1,0),(1,1):
  - first window = 00,01,02,04,05,06,08,09,0A;
  - 4 Done_1row pulses, then one Done_frame.
- N=4, Pad_en=1, same ramp -> 16 windows:
  - (0,0) = 0,0,0,0,00,01,0,04,05;
  - (3,3) = 0A,0B,0,0E,0F,0,0,0,0;
  - exactly 16 AXI beats accepted.
- N=5, Pad_en=0, Stride2=1, ramp 0x00..0x18 -> 4 windows at (0,0),(0,2),(2,0),(2,2); (2,2) has centre 0x12.
- Scenario 1 with m_axis_tready held low 5 cycles at the first window:
  - out_window and m_axis_tvalid stay stable and s_axis_tready=0 during the stall;
  - final window sequence is identical to scenario 1.
- N=4 with tlast on beat 10 -> Error_tlast=1 from the cycle after beat 10; the plane still completes after 16 beats. The next legal Start clears it.
- Start with N=2, Pad_en=0 -> Error_cfg=1 and Busy=0. Then start N=3 and apply Reset after 5 beats: all outputs are 0 the next cycle. Then start N=3 with ramp 0..8 -> single window 0..8, then Done_frame.
